// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - multi-cycle MSB-first magnitude/equality comparator
// Optional SEQ_CMP_EARLY_EXIT_EN: leave SCAN on the first differing chunk instead of after N chunks.
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             neq,
  output logic             lt
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    count;
  logic             decided;
  logic [CHUNK-1:0] ca, cb;
  logic             differ;
  logic             last;

  assign ca        = sa[WIDTH-1 -: CHUNK];
  assign cb        = sb[WIDTH-1 -: CHUNK];
  assign differ    = (ca != cb);
  assign last      = (count == CW'(N - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = SCAN;
      SCAN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
        if (last || (!decided && differ)) state_nx = DONE;
`else
        if (last) state_nx = DONE;
`endif
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      count   <= '0;
      decided <= 1'b0;
      neq     <= 1'b0;
      lt      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            sa             <= a;
            sb             <= b;
            sa[WIDTH-1]    <= a[WIDTH-1] ^ is_signed;
            sb[WIDTH-1]    <= b[WIDTH-1] ^ is_signed;
            count          <= '0;
            decided        <= 1'b0;
            neq            <= 1'b0;
            lt             <= 1'b0;
          end
        end
        SCAN: begin
          sa    <= sa << CHUNK;
          sb    <= sb << CHUNK;
          count <= count + CW'(1);
          if (!decided && differ) begin
            decided <= 1'b1;
            neq     <= 1'b1;
            lt      <= (ca < cb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
